// File: rtl/aes_adapter_pkg.sv
// Shared types and constants for the AES stream adapter.
// Holds the sequencer state enum, the load/read word counts and the
// word-slice helpers used to serialise a 256-bit {pt, key} block.
package aes_adapter_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned LOAD_WORDS = 8;
  localparam int unsigned READ_WORDS = 4;
  localparam int unsigned LOAD_W     = LOAD_WORDS * WORD_W;
  localparam int unsigned IDX_W      = 3;

  // Final index of each multi-cycle state.
  localparam logic [IDX_W-1:0] LOAD_LAST  = IDX_W'(LOAD_WORDS - 1);
  localparam logic [IDX_W-1:0] READ_LAST  = IDX_W'(READ_WORDS);
  localparam logic [IDX_W-1:0] ABORT_LAST = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_READ      = 3'd3,
    ST_OUT_HOLD  = 3'd4,
    ST_ABORT     = 3'd5
  } state_e;

  // Word idx of a load block, most significant word first.
  function automatic logic [WORD_W-1:0] load_word(input logic [LOAD_W-1:0] blk,
                                                  input logic [IDX_W-1:0]  idx);
    return blk[(LOAD_WORDS - 1 - 32'(idx)) * WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/aes_adapter_timeout.sv
// WAIT_DONE watchdog for the AES stream adapter (built only when
// AES_ADAPTER_TIMEOUT_EN is defined).
// Ports: clk, reset (sync, active-high), enable (count this cycle),
//        clear (restart count), expired (count has reached TIMEOUT_CYCLES).
module aes_adapter_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // Saturating counter; expired rises together with count reaching LIMIT.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable && (count != LIMIT)) begin
      count   <= count + CNT_W'(1);
      expired <= ((count + CNT_W'(1)) == LIMIT);
    end
  end

endmodule

// File: rtl/aes_stream_adapter.sv
// Host-side sequencer feeding an AES core over its 32-bit word port.
// Accepts {pt, key} on in_valid/in_ready, loads 8 words into the core,
// waits for core_done, reads 4 ciphertext words and offers them on
// out_valid/out_ready with full backpressure.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_pt/in_key;
//        out_valid/out_ready/out_ct; busy; error; core_* drive/observe the core.
// Optional watchdog: define AES_ADAPTER_TIMEOUT_EN to abort a stuck WAIT_DONE
// after TIMEOUT_CYCLES cycles; otherwise error is tied low.
module aes_stream_adapter
  import aes_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  in_pt,
  input  logic [BLOCK_W-1:0]  in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  out_ct,
  output logic                busy,
  output logic                error,
  output logic                core_reset_n,
  output logic                core_start_n,
  output logic                core_start_read_n,
  output logic [WORD_W-1:0]   core_dword_in,
  input  logic [WORD_W-1:0]   core_dword_out,
  input  logic                core_done
);

  state_e             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [LOAD_W-1:0]  blk;
  logic [LOAD_W-1:0]  load_src;
  logic               accept;

  logic               in_ready_next, out_valid_next, busy_next, error_next;
  logic               core_reset_n_next, core_start_n_next, core_start_read_n_next;
  logic [WORD_W-1:0]  core_dword_in_next;

  assign accept = in_valid && in_ready;

  // Word 0 goes out on the accept edge, before blk has captured the inputs.
  assign load_src = (state == ST_IDLE) ? {in_pt, in_key} : blk;

`ifdef AES_ADAPTER_TIMEOUT_EN
  logic timer_enable, timer_clear, timer_expired;
  assign timer_enable = (state_next == ST_WAIT_DONE);
  assign timer_clear  = (state == ST_IDLE);

  aes_adapter_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (timer_enable),
    .clear   (timer_clear),
    .expired (timer_expired)
  );
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      idx               <= '0;
      in_ready          <= 1'b0;
      out_valid         <= 1'b0;
      busy              <= 1'b0;
      error             <= 1'b0;
      core_reset_n      <= 1'b0;
      core_start_n      <= 1'b1;
      core_start_read_n <= 1'b1;
      core_dword_in     <= '0;
    end else begin
      state             <= state_next;
      idx               <= idx_next;
      in_ready          <= in_ready_next;
      out_valid         <= out_valid_next;
      busy              <= busy_next;
      error             <= error_next;
      core_reset_n      <= core_reset_n_next;
      core_start_n      <= core_start_n_next;
      core_start_read_n <= core_start_read_n_next;
      core_dword_in     <= core_dword_in_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_LOAD;
          idx_next   = '0;
        end
      end
      ST_LOAD: begin
        if (idx == LOAD_LAST) begin
          state_next = ST_WAIT_DONE;
          idx_next   = '0;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        // idx==0 marks the first cycle, where a stale done is ignored.
        idx_next = IDX_W'(1);
        if ((idx != '0) && core_done) begin
          state_next = ST_READ;
          idx_next   = '0;
        end
`ifdef AES_ADAPTER_TIMEOUT_EN
        else if (timer_expired) begin
          state_next = ST_ABORT;
          idx_next   = '0;
        end
`endif
      end
      ST_READ: begin
        if (idx == READ_LAST) begin
          state_next = ST_OUT_HOLD;
          idx_next   = '0;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      ST_OUT_HOLD: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
`ifdef AES_ADAPTER_TIMEOUT_EN
      ST_ABORT: begin
        if (idx == ABORT_LAST) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every port is a flop.
  always_comb begin
    in_ready_next          = (state_next == ST_IDLE);
    busy_next              = (state_next != ST_IDLE);
    out_valid_next         = (state_next == ST_OUT_HOLD);
    core_reset_n_next      = 1'b1;
    core_start_n_next      = !((state_next == ST_LOAD) && (idx_next == '0));
    core_start_read_n_next = !((state_next == ST_READ) && (idx_next == '0));
    core_dword_in_next     = '0;
    error_next             = 1'b0;
    if (state_next == ST_LOAD) begin
      core_dword_in_next = load_word(load_src, idx_next);
    end
`ifdef AES_ADAPTER_TIMEOUT_EN
    error_next = accept ? 1'b0 : error;
    if (state_next == ST_ABORT) begin
      error_next        = 1'b1;
      core_reset_n_next = 1'b0;
    end
`endif
  end

  // Block latch and ciphertext assembly; READ idx 1..4 fills words 0..3.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk    <= '0;
      out_ct <= '0;
    end else begin
      if (accept) begin
        blk <= {in_pt, in_key};
      end
      if ((state == ST_READ) && (idx != '0)) begin
        out_ct[(READ_WORDS - 32'(idx)) * WORD_W +: WORD_W] <= core_dword_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed bench for aes_stream_adapter with a lookup-table AES core model.
// Covers FIPS-197 vectors, load word order, backpressure, stale done,
// mid-load reset, back-to-back blocks and (with AES_ADAPTER_TIMEOUT_EN)
// the WAIT_DONE watchdog abort.
module tb_aes_stream_adapter;

  localparam int CORE_LAT = 6;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [127:0] in_pt, in_key;
  logic         out_valid, out_ready;
  logic [127:0] out_ct;
  logic         busy, error;
  logic         core_reset_n, core_start_n, core_start_read_n;
  logic [31:0]  core_dword_in, core_dword_out;
  logic         core_done;

  int checks = 0;
  int errors = 0;

  logic force_done;
  logic done_en;

  always #5 clk = ~clk;

  aes_stream_adapter #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_pt             (in_pt),
    .in_key            (in_key),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_ct            (out_ct),
    .busy              (busy),
    .error             (error),
    .core_reset_n      (core_reset_n),
    .core_start_n      (core_start_n),
    .core_start_read_n (core_start_read_n),
    .core_dword_in     (core_dword_in),
    .core_dword_out    (core_dword_out),
    .core_done         (core_done)
  );

  // Core model: known FIPS-197 answers, anything else yields a junk marker.
  function automatic logic [127:0] core_lookup(input logic [127:0] key, input logic [127:0] pt);
    if (key == K1 && pt == P1) return C1;
    if (key == K2 && pt == P2) return C2;
    return ~(key ^ pt);
  endfunction

  logic [255:0] m_blk;
  logic [127:0] m_ct;
  logic [31:0]  m_dout;
  logic         m_done;
  int           m_ld, m_lat, m_rd;

  assign m_ct           = core_lookup(m_blk[127:0], m_blk[255:128]);
  assign core_done      = m_done | force_done;
  assign core_dword_out = m_dout;

  always @(posedge clk) begin
    if (!core_reset_n) begin
      m_ld   <= 0;
      m_lat  <= 0;
      m_rd   <= 0;
      m_done <= 1'b0;
      m_dout <= '0;
    end else begin
      if (!core_start_n) begin
        m_blk  <= {m_blk[223:0], core_dword_in};
        m_ld   <= 1;
        m_lat  <= 0;
        m_done <= 1'b0;
      end else if (m_ld > 0 && m_ld < 8) begin
        m_blk <= {m_blk[223:0], core_dword_in};
        m_ld  <= m_ld + 1;
      end else if (m_ld == 8 && !m_done && done_en) begin
        if (m_lat == CORE_LAT - 1) m_done <= 1'b1;
        else                       m_lat  <= m_lat + 1;
      end
      if (!core_start_read_n) begin
        m_dout <= m_ct[127:96];
        m_rd   <= 1;
      end else if (m_rd > 0 && m_rd < 4) begin
        m_dout <= m_ct[127 - 32*m_rd -: 32];
        m_rd   <= m_rd + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one block, then verify the 8 load words (pt words then key words).
  task automatic send(input logic [127:0] key, input logic [127:0] pt, input string tag);
    logic [255:0] blk;
    blk = {pt, key};
    check({tag, "_ready"}, 128'(in_ready), 128'(1));
    in_pt = pt;
    in_key = key;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check({tag, "_start0"}, 128'(core_start_n), 128'(0));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      check($sformatf("%s_word%0d", tag, k), 128'(core_dword_in), 128'(blk[255 - 32*k -: 32]));
      if (k == 1) check({tag, "_start1"}, 128'(core_start_n), 128'(1));
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
    check("out_valid_bound", 128'(out_valid), 128'(1));
  endtask

  logic [127:0] b_key [3];
  logic [127:0] b_pt  [3];
  logic [127:0] b_ct  [3];

  initial begin
    int n;
    int n_acc, n_out, viol;
    logic acc, idle_ok, hs;
    logic [127:0] ct_s;

    reset = 1'b1;
    in_valid = 1'b0;
    in_pt = '0;
    in_key = '0;
    out_ready = 1'b0;
    force_done = 1'b0;
    done_en = 1'b1;

    // Reset values
    repeat (3) tick;
    check("rst_in_ready",  128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_ct",    out_ct, 128'(0));
    check("rst_busy",      128'(busy), 128'(0));
    check("rst_error",     128'(error), 128'(0));
    check("rst_core_rstn", 128'(core_reset_n), 128'(0));
    check("rst_start_n",   128'(core_start_n), 128'(1));
    check("rst_start_rd",  128'(core_start_read_n), 128'(1));
    check("rst_dword_in",  128'(core_dword_in), 128'(0));
    reset = 1'b0;
    tick;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    check("post_rst_core_rstn", 128'(core_reset_n), 128'(1));

    // FIPS-197 vector; out_valid 13 edges after the last load word edge
    send(K1, P1, "fips");
    check("fips_busy", 128'(busy), 128'(1));
    wait_out(n);
    check("fips_latency", 128'(n), 128'(13));
    check("fips_ct", out_ct, C1);

    // Backpressure for 50 cycles
    for (int i = 0; i < 50; i++) begin
      tick;
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_ct", out_ct, C1);
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_ready", 128'(in_ready), 128'(1));

    // Stale done through LOAD and the first WAIT_DONE cycle
    force_done = 1'b1;
    send(K2, P2, "stale");
    tick;
    check("stale_t9_rd", 128'(core_start_read_n), 128'(1));
    tick;
    check("stale_t10_rd", 128'(core_start_read_n), 128'(1));
    check("stale_t10_busy", 128'(busy), 128'(1));
    force_done = 1'b0;
    wait_out(n);
    check("stale_ct", out_ct, C2);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Reset at LOAD index 4
    in_pt = P1;
    in_key = K1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    check("rst4_word", 128'(core_dword_in), 128'(K1[127:96]));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rst4_core_rstn", 128'(core_reset_n), 128'(0));
    check("rst4_out_valid", 128'(out_valid), 128'(0));
    check("rst4_busy", 128'(busy), 128'(0));
    tick;
    check("rst4_in_ready", 128'(in_ready), 128'(1));
    send(K1, P1, "after_rst");
    wait_out(n);
    check("after_rst_ct", out_ct, C1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Back-to-back with in_valid and out_ready held high
    b_key[0] = K1; b_pt[0] = P1; b_ct[0] = C1;
    b_key[1] = K2; b_pt[1] = P2; b_ct[1] = C2;
    b_key[2] = K1; b_pt[2] = P1; b_ct[2] = C1;
    n_acc = 0;
    n_out = 0;
    viol = 0;
    in_key = b_key[0];
    in_pt = b_pt[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && n_out < 3; cyc++) begin
      acc = in_valid && in_ready;
      idle_ok = !busy;
      hs = out_valid && out_ready;
      ct_s = out_ct;
      if (in_ready && busy) viol++;
      tick;
      if (acc) begin
        check("b2b_accept_idle", 128'(idle_ok), 128'(1));
        n_acc++;
        if (n_acc < 3) begin
          in_key = b_key[n_acc];
          in_pt = b_pt[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (hs) begin
        if (n_out < 3) check($sformatf("b2b_ct%0d", n_out), ct_s, b_ct[n_out]);
        n_out++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 128'(n_acc), 128'(3));
    check("b2b_outputs", 128'(n_out), 128'(3));
    check("b2b_ready_while_busy", 128'(viol), 128'(0));
    tick;

`ifdef AES_ADAPTER_TIMEOUT_EN
    // Watchdog: 16 WAIT_DONE cycles, 2 ABORT cycles, sticky error
    done_en = 1'b0;
    send(K2, P2, "to");
    for (int i = 0; i < 16; i++) begin
      tick;
      check("to_wait_core_rstn", 128'(core_reset_n), 128'(1));
      check("to_wait_error", 128'(error), 128'(0));
    end
    tick;
    check("to_abort0_core_rstn", 128'(core_reset_n), 128'(0));
    check("to_abort0_error", 128'(error), 128'(1));
    check("to_abort0_out_valid", 128'(out_valid), 128'(0));
    check("to_abort0_in_ready", 128'(in_ready), 128'(0));
    tick;
    check("to_abort1_core_rstn", 128'(core_reset_n), 128'(0));
    tick;
    check("to_idle_core_rstn", 128'(core_reset_n), 128'(1));
    check("to_idle_in_ready", 128'(in_ready), 128'(1));
    check("to_idle_error", 128'(error), 128'(1));
    check("to_idle_out_valid", 128'(out_valid), 128'(0));
    done_en = 1'b1;
    send(K1, P1, "to_next");
    check("to_error_cleared", 128'(error), 128'(0));
    wait_out(n);
    check("to_next_ct", out_ct, C1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
`endif

    check("final_error", 128'(error), 128'(0));
    check("final_in_ready", 128'(in_ready), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
